// File: rtl/keygen_pkg.sv
// Shared constants and types for the key-generation scheduler:
// coefficient/polynomial types, the K-vector and KxK-matrix packings
// used on the flat ports, and the sequencer state encoding.
package keygen_pkg;

  localparam int W = 32;  // coefficient width (signed two's complement)
  localparam int N = 4;   // coefficients per polynomial
  localparam int K = 2;   // module rank
  localparam int Q = 17;  // modulus

  typedef logic signed [W-1:0] coef_t;
  typedef coef_t [N-1:0]       poly_t;  // coefficient c at bits [c*W +: W]
  typedef poly_t [K-1:0]       vec_t;   // polynomial j at flat index j*N+c
  typedef vec_t  [K-1:0]       mat_t;   // A[i][j] at flat index (i*K+j)*N+c

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    REDUCE,
    OUTPUT
  } state_t;

  // Index width for a counter over n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keygen_scheduler_if.sv
// Start/done handshake between the scheduler and the shared polynomial
// multiplier. The scheduler is the master; the multiplier is the slave.
interface keygen_scheduler_if;
  import keygen_pkg::*;

  logic  mul_start;   // one-cycle request
  poly_t mul_poly_a;  // operand A[i][j], held until mul_done
  poly_t mul_poly_s;  // operand s[j], held until mul_done
  logic  mul_done;    // single-cycle result strobe
  poly_t mul_result;  // product coefficients (signed)

  modport master (
    output mul_start, mul_poly_a, mul_poly_s,
    input  mul_done, mul_result
  );

  modport slave (
    input  mul_start, mul_poly_a, mul_poly_s,
    output mul_done, mul_result
  );

endinterface

// File: rtl/mod_q_reduce.sv
// Combinational reduction of one signed coefficient to the canonical
// range [0, Q-1], negative inputs included.
module mod_q_reduce
  import keygen_pkg::*;
(
  input  coef_t x,
  output coef_t y
);

  localparam coef_t QC = coef_t'(Q);

  coef_t rem;

  // Signed % truncates toward zero, so a negative remainder needs exactly
  // one +Q; this equals ((x % Q) + Q) % Q without a second divider.
  always_comb begin
    rem = x % QC;
    y   = (rem < 0) ? rem + QC : rem;
  end

endmodule

// File: rtl/keygen_scheduler.sv
// Key-generation sequencer: t = A*s + e (mod Q) through one shared
// polynomial multiplier. The K*K products are issued in row-major order,
// summed per row, then each row gets e added and is reduced in one cycle.
// Optional feature macro: KEYGEN_SCHED_TIMEOUT_EN (abort with an err pulse
// if the multiplier stays silent for TIMEOUT cycles in WAIT).
module keygen_scheduler
  import keygen_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  input  logic [K*K*N*W-1:0] a_in,
  input  logic [K*N*W-1:0]   s_in,
  input  logic [K*N*W-1:0]   e_in,
  output logic               mul_start,
  output logic [N*W-1:0]     mul_poly_a,
  output logic [N*W-1:0]     mul_poly_s,
  input  logic               mul_done,
  input  logic [N*W-1:0]     mul_result,
  output logic [K*N*W-1:0]   t_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err
);

  localparam int RW = idx_w(K);
  typedef logic [RW-1:0] idx_t;
  localparam idx_t LAST = idx_t'(K - 1);

  state_t state, state_nx;

  mat_t  a_q;
  vec_t  s_q, e_q, acc, t_q;
  idx_t  row, col;   // product p = row*K + col
  idx_t  red_row;    // row being reduced
  poly_t mul_res;
  poly_t acc_sum;
  poly_t red_in;
  coef_t red_out [N];
  logic  last_prod, last_row, timeout_hit;

  assign last_prod = (row == LAST) && (col == LAST);
  assign last_row  = (red_row == LAST);
  assign mul_res   = poly_t'(mul_result);

  // Operands are muxed from the latched inputs; row/col only advance on
  // mul_done, so both stay stable from mul_start through WAIT.
  assign mul_poly_a = a_q[row][col];
  assign mul_poly_s = s_q[col];
  assign t_out      = t_q;

`ifdef KEYGEN_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  assign timeout_hit = (state == WAIT) && !mul_done &&
                       (wait_cnt == CW'(TIMEOUT - 1));
  assign err         = err_q;

  // Cycles spent in the current WAIT visit; any other state clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values no matter how blocks are ordered.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and the handshake outputs decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_nx  = state;
    busy      = (state != IDLE);
    mul_start = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:   if (start) state_nx = ISSUE;
      ISSUE: begin
        mul_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (mul_done)         state_nx = last_prod ? REDUCE : ISSUE;
        else if (timeout_hit) state_nx = IDLE;
      end
      REDUCE: if (last_row) state_nx = OUTPUT;
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Row accumulate (W-bit wrap) and the e-added row fed to the reducers.
  always_comb begin
    acc_sum = '0;
    red_in  = '0;
    for (int c = 0; c < N; c++) begin
      acc_sum[c] = acc[row][c] + mul_res[c];
      red_in[c]  = acc[red_row][c] + e_q[red_row][c];
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_red
    mod_q_reduce u_red (
      .x (red_in[c]),
      .y (red_out[c])
    );
  end

  // Job registers: input capture, per-row accumulation, reduced result rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these arrays are reset as well, because zero operands, accumulators and t_out after reset are visible behaviour.
      a_q     <= '0;
      s_q     <= '0;
      e_q     <= '0;
      acc     <= '0;
      t_q     <= '0;
      row     <= '0;
      col     <= '0;
      red_row <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= mat_t'(a_in);
            s_q <= vec_t'(s_in);
            e_q <= vec_t'(e_in);
            acc <= '0;
            row <= '0;
            col <= '0;
          end
        end
        WAIT: begin
          if (mul_done) begin
            acc[row] <= acc_sum;
            if (last_prod) begin
              red_row <= '0;
            end else if (col == LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end else if (timeout_hit) begin
            acc <= '0;
          end
        end
        REDUCE: begin
          for (int c = 0; c < N; c++) t_q[red_row][c] <= red_out[c];
          if (!last_row) red_row <= red_row + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keygen_scheduler.sv
// Bench for keygen_scheduler: a table of directed jobs, hand-written
// sequences for stall/reset/timeout corners, then random jobs checked
// against a plain-arithmetic model of t = A*s + e mod Q. The multiplier
// is modelled here as a negacyclic product mod x^N+1 with latency L.
module tb_keygen_scheduler;
  import keygen_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               busy;
  logic [K*K*N*W-1:0] a_in;
  logic [K*N*W-1:0]   s_in;
  logic [K*N*W-1:0]   e_in;
  logic [K*N*W-1:0]   t_out;
  logic               out_valid;
  logic               out_ready;
  logic               err;

  keygen_scheduler_if bus ();

  keygen_scheduler #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .a_in       (a_in),
    .s_in       (s_in),
    .e_in       (e_in),
    .mul_start  (bus.mul_start),
    .mul_poly_a (bus.mul_poly_a),
    .mul_poly_s (bus.mul_poly_s),
    .mul_done   (bus.mul_done),
    .mul_result (bus.mul_result),
    .t_out      (t_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic poly_t negacyc(input poly_t a, input poly_t b);
    int    r [N];
    poly_t p;
    for (int k = 0; k < N; k++) r[k] = 0;
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++) begin
        if (x + y < N) r[x + y]     = r[x + y]     + int'(a[x]) * int'(b[y]);
        else           r[x + y - N] = r[x + y - N] - int'(a[x]) * int'(b[y]);
      end
    for (int k = 0; k < N; k++) p[k] = coef_t'(r[k]);
    return p;
  endfunction

  function automatic vec_t ref_t(input mat_t a, input vec_t s, input vec_t e);
    int    sum [K][N];
    poly_t pr;
    vec_t  t;
    int    x;
    for (int i = 0; i < K; i++)
      for (int c = 0; c < N; c++) sum[i][c] = int'(e[i][c]);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        pr = negacyc(a[i][j], s[j]);
        for (int c = 0; c < N; c++) sum[i][c] = sum[i][c] + int'(pr[c]);
      end
    for (int i = 0; i < K; i++)
      for (int c = 0; c < N; c++) begin
        x = sum[i][c];
        t[i][c] = coef_t'(((x % Q) + Q) % Q);
      end
    return t;
  endfunction

  function automatic poly_t mkp(input int c0, input int c1, input int c2, input int c3);
    return {coef_t'(c3), coef_t'(c2), coef_t'(c1), coef_t'(c0)};
  endfunction

  function automatic coef_t rnd_coef(input bit wide);
    if (wide) return coef_t'($urandom);
    return coef_t'(int'($urandom_range(100)) - 50);
  endfunction

  // ---------------- multiplier model ----------------
  // mode 0: negacyclic product, 1: every coefficient 16, 2: never answer
  int    mul_lat  = 1;
  int    mul_mode = 0;
  int    mul_cnt  = 0;
  poly_t mul_prod;

  initial begin
    bus.mul_done   = 1'b0;
    bus.mul_result = '0;
    forever begin
      @(negedge clk);
      bus.mul_done = 1'b0;
      if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0) begin
          bus.mul_done   = 1'b1;
          bus.mul_result = mul_prod;
        end
      end
      if (bus.mul_start && mul_mode != 2) begin
        mul_cnt  = mul_lat;
        mul_prod = (mul_mode == 1) ? {N{coef_t'(16)}}
                                   : negacyc(bus.mul_poly_a, bus.mul_poly_s);
      end
    end
  end

  // ---------------- job driver ----------------
  // Drives start in "cycle 0"; cyc is the number of edges until out_valid.
  task automatic run_job(input mat_t a, input vec_t s, input vec_t e,
                         input int ready_delay, output vec_t t, output int cyc);
    a_in  = a;
    s_in  = s;
    e_in  = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (!out_valid && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) check("out_valid_timeout", 256'(out_valid), 256'(1));
    t = vec_t'(t_out);
    repeat (ready_delay) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  typedef struct {
    string name;
    mat_t  a;
    vec_t  s;
    vec_t  e;
    int    mode;
    int    lat;
    vec_t  t_exp;
    int    cyc_exp;
  } tv_t;

  tv_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    poly_t one, zero;
    vec_t  t, t_exp;
    mat_t  a;
    vec_t  s, e;
    int    cyc, pulses, first_k, ov_seen, lat;

    one  = mkp(1, 0, 0, 0);
    zero = '0;

    tbl[0] = '{"identity", {{one, zero}, {zero, one}},
               {mkp(7, 8, 9, 10), mkp(3, 4, 5, 6)}, '0, 0, 1,
               {mkp(7, 8, 9, 10), mkp(3, 4, 5, 6)}, 11};
    tbl[1] = '{"e_only", '0, {mkp(1, 2, 3, 4), mkp(5, 6, 7, 8)},
               {mkp(16, 33, -17, 5), mkp(-20, -1, 17, 0)}, 0, 2,
               {mkp(16, 16, 0, 5), mkp(14, 16, 0, 0)}, 15};
    tbl[2] = '{"forced16", {{one, zero}, {zero, one}},
               {mkp(1, 1, 1, 1), mkp(2, 2, 2, 2)}, '0, 1, 1,
               {mkp(15, 15, 15, 15), mkp(15, 15, 15, 15)}, 11};
    tbl[3] = '{"negacyc_wrap", {{zero, zero}, {mkp(0, 1, 0, 0), zero}},
               {mkp(1, 2, 3, 4), mkp(9, 9, 9, 9)},
               {mkp(-1, 18, 0, 0), zero}, 0, 3,
               {mkp(16, 1, 0, 0), mkp(13, 1, 2, 3)}, 19};
    tbl[4] = '{"scalar_neg", {{mkp(2, 0, 0, 0), mkp(2, 0, 0, 0)}, {mkp(2, 0, 0, 0), mkp(2, 0, 0, 0)}},
               {mkp(-5, 0, 0, 0), mkp(3, 0, 0, 0)},
               {mkp(0, 0, 0, 100), zero}, 0, 1,
               {mkp(13, 0, 0, 15), mkp(13, 0, 0, 0)}, 11};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    a_in = '0; s_in = '0; e_in = '0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;

    check("rst_busy",      256'(busy),          256'(0));
    check("rst_mul_start", 256'(bus.mul_start), 256'(0));
    check("rst_out_valid", 256'(out_valid),     256'(0));
    check("rst_err",       256'(err),           256'(0));
    check("rst_t_out",     256'(t_out),         256'(0));
    check("rst_poly_a",    256'(bus.mul_poly_a), 256'(0));
    check("rst_poly_s",    256'(bus.mul_poly_s), 256'(0));

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      mul_mode = tbl[v].mode;
      mul_lat  = tbl[v].lat;
      run_job(tbl[v].a, tbl[v].s, tbl[v].e, v % 3, t, cyc);
      check({tbl[v].name, "_t"},    256'(t),    256'(tbl[v].t_exp));
      check({tbl[v].name, "_cyc"},  256'(cyc),  256'(tbl[v].cyc_exp));
      check({tbl[v].name, "_idle"}, 256'(busy), 256'(0));
    end
    mul_mode = 0;
    mul_lat  = 1;

    // Output stall with start pulsed mid-job and during OUTPUT.
    a_in = tbl[0].a; s_in = tbl[0].s; e_in = tbl[0].e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; a_in = '1; s_in = '1; e_in = '1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 400) begin @(posedge clk); #1; cyc++; end
    check("hold_reach", 256'(out_valid), 256'(1));
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      check("hold_valid", 256'(out_valid), 256'(1));
      check("hold_t",     256'(t_out),     256'(tbl[0].t_exp));
      check("hold_busy",  256'(busy),      256'(1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    check("hs_busy",   256'(busy),      256'(0));
    check("hs_valid",  256'(out_valid), 256'(0));
    check("hs_t_hold", 256'(t_out),     256'(tbl[0].t_exp));
    repeat (3) begin @(posedge clk); #1; end
    check("hs_no_second_job", 256'(busy), 256'(0));

    // Reset while waiting on the third product; its done arrives late in IDLE.
    mul_lat = 3;
    a_in = tbl[0].a; s_in = tbl[0].s; e_in = tbl[0].e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; cyc = 0;
    while (pulses < 3 && cyc < 100) begin
      if (bus.mul_start) pulses++;
      if (pulses < 3) begin @(posedge clk); #1; cyc++; end
    end
    check("rst_mid_reach", 256'(pulses), 256'(3));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy",      256'(busy),          256'(0));
    check("rst_mid_mul_start", 256'(bus.mul_start), 256'(0));
    check("rst_mid_valid",     256'(out_valid),     256'(0));
    ov_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy || out_valid) ov_seen = 1;
    end
    check("late_done_ignored", 256'(ov_seen), 256'(0));
    mul_lat = 1;
    run_job(tbl[0].a, tbl[0].s, tbl[0].e, 0, t, cyc);
    check("after_rst_t", 256'(t), 256'(tbl[0].t_exp));

    // Multiplier never answers.
    mul_mode = 2;
    a_in = tbl[0].a; s_in = tbl[0].s; e_in = tbl[0].e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!bus.mul_start && cyc < 20) begin @(posedge clk); #1; cyc++; end
    @(posedge clk);  // enters WAIT
    pulses = 0; first_k = 0; ov_seen = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (err) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
      if (out_valid) ov_seen = 1;
    end
`ifdef KEYGEN_SCHED_TIMEOUT_EN
    check("to_err_pulses", 256'(pulses),  256'(1));
    check("to_err_cycle",  256'(first_k), 256'(8));
    check("to_no_valid",   256'(ov_seen), 256'(0));
    check("to_idle",       256'(busy),    256'(0));
`else
    check("to_err_zero",   256'(pulses),  256'(0));
    check("to_no_valid",   256'(ov_seen), 256'(0));
    check("to_still_busy", 256'(busy),    256'(1));
`endif
    mul_mode = 0;
    do_reset();
    repeat (3) begin @(posedge clk); #1; end

    // Random jobs against the reference model.
    for (int it = 0; it < 24; it++) begin
      lat     = int'($urandom_range(1, 4));
      mul_lat = lat;
      for (int i = 0; i < K; i++) begin
        for (int c = 0; c < N; c++) begin
          s[i][c] = rnd_coef(it[0]);
          e[i][c] = rnd_coef(it[0]);
          for (int j = 0; j < K; j++) a[i][j][c] = rnd_coef(it[0]);
        end
      end
      t_exp = ref_t(a, s, e);
      run_job(a, s, e, int'($urandom_range(0, 3)), t, cyc);
      check("rand_t",   256'(t),   256'(t_exp));
      check("rand_cyc", 256'(cyc), 256'(1 + K * K * (lat + 1) + K));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
